fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
Shares the single-port 320x240x2-bit frame-buffer RAM between two requesters: VGA scanout (read-only, latency-critical) and game logic (read/write, with a request/grant handshake). It drives the RAM port, tags each read in flight, and routes the returned data to its owner. It sits between game_logic, the VGA pixel fetcher and the frame-buffer RAM. A starvation guard guarantees game-logic progress; address range checking protects the RAM from out-of-range accesses.

Parameters:
ADDR_W, 19, RAM address width
DATA_W, 2, pixel width
FB_WORDS, 76800, valid addresses 0..FB_WORDS-1
RD_LATENCY, 1, cycles from address-sampling edge to valid ram_read_data (1..4)
STARVE_LIMIT, 8, consecutive denied game cycles before game is forced a slot

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
vid_req  in  1  scanout read request, single cycle, no handshake
vid_addr  in  ADDR_W  scanout address
vid_rvalid  out  1  scanout read data valid
vid_rdata  out  DATA_W  scanout pixel
vid_drop  out  1  pulse: this cycle's vid_req was not serviced
game_req  in  1  game access request, held until game_gnt
game_we  in  1  1 = write, 0 = read
game_addr  in  ADDR_W  game address
game_wdata  in  DATA_W  game write pixel
game_gnt  out  1  game access accepted this cycle
game_rvalid  out  1  game read data valid
game_rdata  out  DATA_W  game read pixel
ram_address  out  ADDR_W  RAM address
ram_write_enabled  out  1  RAM write strobe
ram_write_data  out  DATA_W  RAM write pixel
ram_read_data  in  DATA_W  RAM read pixel
range_err  out  1  sticky: an out-of-range access occurred

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- Reset cycle: game_gnt, vid_drop, vid_rvalid and game_rvalid are 0. ram_write_enabled is 0. ram_address and ram_write_data are 0. The tag pipeline is flushed, so reads in flight never produce rvalid. starve_cnt and range_err are cleared.
- Arbitration is combinational within a cycle and evaluated in this order:
  1. forced = (starve_cnt == STARVE_LIMIT) && game_req. Game wins; vid_drop = vid_req.
  2. Otherwise, if vid_req, video wins.
  3. Otherwise, if game_req, game wins.
  4. Otherwise the port is idle.
- RAM port: the winner's address, write enable and write data drive the port in the grant cycle. Idle drives ram_address 0, ram_write_enabled 0, ram_write_data 0.
- starve_cnt is a 0..STARVE_LIMIT saturating counter. It increments on cycles with game_req && !game_gnt. It clears when game_gnt is high or game_req is low.
- Handshake: the game holds addr/we/wdata stable while game_req is high and game_gnt is low. The transfer completes on the edge where game_gnt=1. Dropping game_req before the grant abandons the request, with no side effects. Back-to-back grants are allowed.
- Read return: a read granted in cycle N gives rvalid=1 for its owner in cycle N+RD_LATENCY, with rdata = ram_read_data in that cycle. Writes produce no rvalid. Ordering is per owner, in grant order; the tag pipeline is RD_LATENCY deep.
- Non-valid rdata: whenever the owner's rvalid is 0, its rdata is 0.
- Out-of-range access (addr >= FB_WORDS), either requester:
  - the access is still granted;
  - ram_write_enabled is suppressed;
  - ram_address is driven to 0;
  - a read returns rvalid with rdata 2'b00;
  - range_err sets on the grant edge and holds until reset.
- Simultaneous events:
  - vid_req and game_req together without forced: video is served; game waits and starve_cnt increments.
  - Forced slot with no vid_req: game is served and vid_drop stays 0.
- Width rules: address compare is unsigned ADDR_W. starve_cnt width is $clog2(STARVE_LIMIT+1).

Decomposition:
- Add to tron_types:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_WORDS=FB_WIDTH*FB_HEIGHT;
  - pixel_t enum {PIX_EMPTY=2'b00, PIX_P1=2'b01, PIX_P2=2'b10, PIX_BORDER=2'b11};
  - owner_t enum {OWN_NONE, OWN_VID, OWN_GAME}.
- Sub-module fb_rd_tag_pipe: an RD_LATENCY-deep shift register of {owner_t, oor} with a synchronous flush. It outputs the tag aligned with ram_read_data.

Test Plan:
- Reset mid-read: game read granted at address 5, reset asserted the next cycle (RD_LATENCY=2) -> no game_rvalid ever appears for it; all outputs 0 during reset.
- Idle-slot game write then read, no vid_req: write addr 321 data 2'b10 -> game_gnt the same cycle, ram_write_enabled=1, ram_address=321. Read addr 321 -> game_rvalid RD_LATENCY cycles later, game_rdata=2'b10.
- Contention: vid_req every cycle and game_req held, STARVE_LIMIT=8 -> game waits exactly 8 cycles, game_gnt in cycle 9, vid_drop=1 in that cycle only, video served again the cycle after.
- Video-priority stream: vid_req on alternate cycles, addresses 0,1,2,... with game_req held -> game granted in every gap, vid_drop never asserts, and vid_rdata returns in address order with RD_LATENCY spacing.
- Out-of-range write: game write addr 76800 data 2'b11 -> granted, ram_write_enabled=0, range_err=1 from the next cycle, and it stays 1 until reset.
- Abandon: game_req high for 3 cycles under video contention, then low -> no grant, no RAM write, starve_cnt returns to 0.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// Shared frame-buffer types: geometry, pixel codes and read-tag format
// used by the frame-buffer arbiter and its read-return pipeline.
package fb_arbiter_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    PIX_EMPTY  = 2'b00,
    PIX_P1     = 2'b01,
    PIX_P2     = 2'b10,
    PIX_BORDER = 2'b11
  } pixel_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_GAME
  } owner_t;

  // Travels alongside each RAM access so returned data can be routed.
  typedef struct packed {
    owner_t owner;
    logic   oor;
  } rd_tag_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bus bundle between the requesters, the frame-buffer arbiter and the RAM port.
// The arbiter uses the slave modport; requesters and the RAM use master.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 2
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_drop;

  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic [DATA_W-1:0] game_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enabled;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data;

  logic              range_err;

  modport master (
    output vid_req, vid_addr, game_req, game_we, game_addr, game_wdata, ram_read_data,
    input  vid_rvalid, vid_rdata, vid_drop, game_gnt, game_rvalid, game_rdata,
    input  ram_address, ram_write_enabled, ram_write_data, range_err
  );

  modport slave (
    input  vid_req, vid_addr, game_req, game_we, game_addr, game_wdata, ram_read_data,
    output vid_rvalid, vid_rdata, vid_drop, game_gnt, game_rvalid, game_rdata,
    output ram_address, ram_write_enabled, ram_write_data, range_err
  );
endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Delays the per-access tag by RD_LATENCY cycles so it lines up with the
// RAM's read data; flush discards every access still in flight.
module fb_rd_tag_pipe
  import fb_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clock,
  input  logic    flush,
  input  rd_tag_t tag_p0,
  output rd_tag_t tag_out
);

  rd_tag_t tag_p [RD_LATENCY];

  always_ff @(posedge clock) begin
    if (flush) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_p[i] <= '{owner: OWN_NONE, oor: 1'b0};
    end else begin
      tag_p[0] <= tag_p0;
      for (int i = 1; i < RD_LATENCY; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[RD_LATENCY-1];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: video scanout has priority, game logic
// gets idle slots plus a forced slot after STARVE_LIMIT denied cycles.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 2,
  parameter int FB_WORDS     = fb_arbiter_pkg::FB_WORDS,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input logic         clock,
  input logic         reset,
  fb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ADDR_END   = ADDR_W'(FB_WORDS);

  logic [CNT_W-1:0]  starve_cnt;
  logic              range_err_q;
  logic              forced;
  logic              vid_win;
  logic              game_win;
  logic              acc_oor;
  logic [ADDR_W-1:0] acc_addr;
  rd_tag_t           tag_p0;
  rd_tag_t           tag_rd;

  always_comb begin
    forced   = 1'b0;
    vid_win  = 1'b0;
    game_win = 1'b0;
    if (!reset) begin
      forced = (starve_cnt == STARVE_MAX) && bus.game_req;
      if (forced)            game_win = 1'b1;
      else if (bus.vid_req)  vid_win  = 1'b1;
      else if (bus.game_req) game_win = 1'b1;
    end

    acc_addr = vid_win ? bus.vid_addr : (game_win ? bus.game_addr : '0);
    acc_oor  = (vid_win || game_win) && (acc_addr >= ADDR_END);

    // Out-of-range accesses are granted but never reach the RAM array.
    bus.vid_drop          = forced && bus.vid_req;
    bus.game_gnt          = game_win;
    bus.ram_address       = acc_oor ? '0 : acc_addr;
    bus.ram_write_enabled = game_win && bus.game_we && !acc_oor;
    bus.ram_write_data    = game_win ? bus.game_wdata : '0;

    tag_p0.owner = vid_win ? OWN_VID : ((game_win && !bus.game_we) ? OWN_GAME : OWN_NONE);
    tag_p0.oor   = acc_oor;

    bus.vid_rvalid  = !reset && (tag_rd.owner == OWN_VID);
    bus.game_rvalid = !reset && (tag_rd.owner == OWN_GAME);
    bus.vid_rdata   = (bus.vid_rvalid && !tag_rd.oor) ? bus.ram_read_data : '0;
    bus.game_rdata  = (bus.game_rvalid && !tag_rd.oor) ? bus.ram_read_data : '0;
    bus.range_err   = range_err_q && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt  <= '0;
      range_err_q <= 1'b0;
    end else begin
      if (bus.game_req && !game_win)
        starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      if (acc_oor) range_err_q <= 1'b1;
    end
  end

  // Read-return stage boundary: tag pipe aligns owner with ram_read_data
  fb_rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clock  (clock),
    .flush  (reset),
    .tag_p0 (tag_p0),
    .tag_out(tag_rd)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus randomized traffic, all
// compared per cycle against a transaction-level model and a RAM model.
module tb_fb_arbiter;
  import fb_arbiter_pkg::*;

  localparam int AW    = 19;
  localparam int DW    = 2;
  localparam int RDL   = 2;
  localparam int SL    = 8;
  localparam int WORDS = 76800;
  localparam logic [AW-1:0] WORDS_A = AW'(WORDS);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(WORDS), .RD_LATENCY(RDL), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // RAM model driven purely by the DUT's RAM port
  bit [1:0] ram_mem  [WORDS];
  bit [1:0] ram_pipe [RDL];
  always @(posedge clock) begin
    ram_pipe[0] <= (bus.ram_address < WORDS_A) ? ram_mem[bus.ram_address] : 2'b01;
    for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
    if (bus.ram_write_enabled && bus.ram_address < WORDS_A)
      ram_mem[bus.ram_address] <= bus.ram_write_data;
  end
  assign bus.ram_read_data = ram_pipe[RDL-1];

  // Transaction-level reference state
  typedef struct {
    int         due;
    bit         vid;
    logic [1:0] data;
  } ret_t;

  bit [1:0] ref_mem [WORDS];
  ret_t     ret_q[$];
  int       starve_m;
  bit       rerr_m;
  bit       last_g;
  int       cyc;
  int       total;
  int       bad;

  // randomized-phase scratch
  bit              pend;
  bit              pwe;
  logic [AW-1:0]   pa;
  logic [1:0]      pd;
  bit              vr;
  logic [AW-1:0]   vaddr;
  int              waits;
  int              grants;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 15) == 0) return WORDS_A + AW'($urandom_range(0, 4000));
    return AW'($urandom_range(0, 63));
  endfunction

  task automatic step(input bit r, input bit vreq, input logic [AW-1:0] va,
                      input bit greq, input bit gwe, input logic [AW-1:0] ga,
                      input logic [1:0] gwd);
    bit forced, v, g, oor, e_vr, e_gr;
    logic [AW-1:0] a;
    logic [1:0] e_vd, e_gd;
    reset          = r;
    bus.vid_req    = vreq;
    bus.vid_addr   = va;
    bus.game_req   = greq;
    bus.game_we    = gwe;
    bus.game_addr  = ga;
    bus.game_wdata = gwd;
    #1;
    forced = 1'b0; v = 1'b0; g = 1'b0; a = '0;
    if (!r) begin
      forced = (starve_m == SL) && greq;
      if (forced)    g = 1'b1;
      else if (vreq) v = 1'b1;
      else if (greq) g = 1'b1;
    end
    if (v) a = va;
    else if (g) a = ga;
    oor = (v || g) && (a >= WORDS_A);
    e_vr = 1'b0; e_gr = 1'b0; e_vd = 2'b00; e_gd = 2'b00;
    if (!r && ret_q.size() > 0 && ret_q[0].due == cyc) begin
      if (ret_q[0].vid) begin e_vr = 1'b1; e_vd = ret_q[0].data; end
      else begin e_gr = 1'b1; e_gd = ret_q[0].data; end
    end
    chk("game_gnt",    32'(bus.game_gnt),          32'(g));
    chk("vid_drop",    32'(bus.vid_drop),          32'(forced && vreq));
    chk("ram_address", 32'(bus.ram_address),       oor ? 32'd0 : 32'(a));
    chk("ram_we",      32'(bus.ram_write_enabled), 32'(g && gwe && !oor));
    chk("ram_wdata",   32'(bus.ram_write_data),    g ? 32'(gwd) : 32'd0);
    chk("vid_rvalid",  32'(bus.vid_rvalid),        32'(e_vr));
    chk("vid_rdata",   32'(bus.vid_rdata),         32'(e_vd));
    chk("game_rvalid", 32'(bus.game_rvalid),       32'(e_gr));
    chk("game_rdata",  32'(bus.game_rdata),        32'(e_gd));
    chk("range_err",   32'(bus.range_err),         r ? 32'd0 : 32'(rerr_m));
    @(posedge clock);
    if (r) begin
      starve_m = 0;
      rerr_m   = 1'b0;
      ret_q.delete();
    end else begin
      if (ret_q.size() > 0 && ret_q[0].due == cyc) void'(ret_q.pop_front());
      if (oor) rerr_m = 1'b1;
      if (v || (g && !gwe)) ret_q.push_back('{due: cyc + RDL, vid: v, data: oor ? 2'b00 : ref_mem[a]});
      if (g && gwe && !oor) ref_mem[a] = gwd;
      starve_m = (greq && !g) ? ((starve_m < SL) ? starve_m + 1 : SL) : 0;
    end
    last_g = g;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; starve_m = 0; rerr_m = 1'b0; last_g = 1'b0;
    reset = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0; bus.game_req = 1'b0;
    bus.game_we = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    @(negedge clock);

    // reset with live requests: everything must stay quiet
    step(1'b1, 1'b1, 19'd7, 1'b1, 1'b1, 19'd9, 2'b11);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00);

    // idle-slot write then read-back at 321
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 19'd321, 2'b10);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 19'd321, 2'b00);
    idle(3);

    // reset mid-read: the in-flight read at 5 must vanish
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 19'd5, 2'b00);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00);
    idle(3);

    // seed addresses 0..7 for the video stream
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(i), 2'(i * 3 + 1));

    // contention: game waits exactly STARVE_LIMIT cycles
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, 19'd2, 2'b00);
      if (last_g) break;
      waits++;
    end
    chk("contention_wait", 32'(waits), 32'(SL));
    step(1'b0, 1'b1, 19'd3, 1'b0, 1'b0, '0, 2'b00);
    idle(3);

    // video on alternate cycles, game granted in each gap
    grants = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, (k % 2) == 0, AW'(k / 2), 1'b1, k[2], AW'(100 + k), 2'(k));
      if (last_g) grants++;
    end
    chk("alt_grants", 32'(grants), 32'd8);
    idle(3);

    // abandon under contention, then starve count must restart from zero
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'(i), 1'b1, 1'b1, 19'd40, 2'b11);
    step(1'b0, 1'b1, 19'd4, 1'b0, 1'b0, '0, 2'b00);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, 19'd40, 2'b00);
      if (last_g) break;
      waits++;
    end
    chk("abandon_restart_wait", 32'(waits), 32'(SL));
    idle(3);

    // out-of-range write and video read; range_err becomes sticky
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 19'd76800, 2'b11);
    idle(2);
    step(1'b0, 1'b1, 19'd80000, 1'b0, 1'b0, '0, 2'b00);
    idle(4);

    // randomized traffic with a well-behaved game handshake
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      vr    = $urandom_range(0, 2) != 0;
      vaddr = rnd_addr();
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        pwe  = $urandom_range(0, 1) == 1;
        pa   = rnd_addr();
        pd   = 2'($urandom_range(0, 3));
      end else if (pend && $urandom_range(0, 15) == 0) begin
        pend = 1'b0;
      end
      step(1'b0, vr, vaddr, pend, pwe, pa, pd);
      if (last_g) pend = 1'b0;
    end
    idle(3);

    // reset clears range_err
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
